// File: rtl/isp_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : isp_wb_pkg
// Brief   : Shared types and constants for the white-balance gain stage.
// Revision: 1.0 - initial release
// ============================================================================
package isp_wb_pkg;

    // CFA order at the first pixel of a frame
    typedef enum logic [1:0] {
        BAYER_RGGB = 2'd0,
        BAYER_GRBG = 2'd1,
        BAYER_GBRG = 2'd2,
        BAYER_BGGR = 2'd3
    } bayer_e;

    // Channel of a pixel, expressed in RGGB terms
    typedef enum logic [1:0] {
        FMT_R  = 2'd0,
        FMT_GR = 2'd1,
        FMT_GB = 2'd2,
        FMT_B  = 2'd3
    } fmt_e;

    localparam int c_GAIN_UNITY = 16;
    localparam int c_GAIN_FRAC  = 4;

endpackage
`default_nettype wire

// File: rtl/isp_wb_if.sv
`default_nettype none
// ============================================================================
// Module  : isp_wb_if
// Brief   : Raw Bayer pixel stream (line valid, frame sync, pixel).
// Revision: 1.0 - initial release
// ============================================================================
interface isp_wb_if #(
    parameter int BITS = 8
) ();
    logic            href;
    logic            vsync;
    logic [BITS-1:0] raw;

    modport master (output href, vsync, raw);
    modport slave  (input  href, vsync, raw);
endinterface
`default_nettype wire

// File: rtl/isp_wb_stat.sv
`default_nettype none
// ============================================================================
// Module  : isp_wb_stat
// Brief   : Per-channel saturating pre-gain sums, latched at frame start.
// Revision: 1.0 - initial release
// ============================================================================
module isp_wb_stat
    import isp_wb_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int STAT_BITS = 32
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 acc_en,
    input  fmt_e                 fmt,
    input  logic [BITS-1:0]      raw,
    input  logic                 vsync_rise,
    output logic [STAT_BITS-1:0] stat_sum_r,
    output logic [STAT_BITS-1:0] stat_sum_gr,
    output logic [STAT_BITS-1:0] stat_sum_gb,
    output logic [STAT_BITS-1:0] stat_sum_b,
    output logic                 stat_done
);

    logic [STAT_BITS-1:0] r_acc [4];
    logic [STAT_BITS-1:0] r_sum [4];
    logic                 r_done;
    logic [STAT_BITS:0]   w_add;
    logic [STAT_BITS-1:0] w_sat;

    // One spare bit catches the carry so the sum pins at all-ones
    assign w_add = {1'b0, r_acc[fmt]} + (STAT_BITS+1)'(raw);
    assign w_sat = w_add[STAT_BITS] ? {STAT_BITS{1'b1}} : w_add[STAT_BITS-1:0];

    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_acc[i] <= '0;
                r_sum[i] <= '0;
            end
            r_done <= 1'b0;
        end else begin
            r_done <= vsync_rise;
            if (vsync_rise) begin
                for (int i = 0; i < 4; i++) begin
                    r_sum[i] <= r_acc[i];
                    r_acc[i] <= '0;
                end
            end else if (acc_en) begin
                r_acc[fmt] <= w_sat;
            end
        end
    end

    assign stat_sum_r  = r_sum[FMT_R];
    assign stat_sum_gr = r_sum[FMT_GR];
    assign stat_sum_gb = r_sum[FMT_GB];
    assign stat_sum_b  = r_sum[FMT_B];
    assign stat_done   = r_done;

endmodule
`default_nettype wire

// File: rtl/isp_wb.sv
`default_nettype none
// ============================================================================
// Module  : isp_wb
// Brief   : Bayer white-balance gain with round/clip and per-frame AWB sums.
// Revision: 1.0 - initial release
// ============================================================================
module isp_wb
    import isp_wb_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int GAIN_BITS = 8,
    parameter int STAT_BITS = 32,
    parameter int BAYER     = 0
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic [GAIN_BITS-1:0] gain_r,
    input  logic [GAIN_BITS-1:0] gain_gr,
    input  logic [GAIN_BITS-1:0] gain_gb,
    input  logic [GAIN_BITS-1:0] gain_b,
    isp_wb_if.slave              pix_in,
    isp_wb_if.master             pix_out,
    output logic [STAT_BITS-1:0] stat_sum_r,
    output logic [STAT_BITS-1:0] stat_sum_gr,
    output logic [STAT_BITS-1:0] stat_sum_gb,
    output logic [STAT_BITS-1:0] stat_sum_b,
    output logic                 stat_done
);

    localparam int c_PW    = BITS + GAIN_BITS;
    localparam int c_ROUND = 1 << (c_GAIN_FRAC - 1);

    logic                 r_odd_pix;
    logic                 r_odd_line;
    logic                 r_href_prev;
    logic                 r_vsync_prev;
    logic                 w_vsync_rise;
    fmt_e                 w_fmt;

    logic [GAIN_BITS-1:0] r_gain [4];

    logic [BITS-1:0]      r_s1_raw;
    fmt_e                 r_s1_fmt;
    logic [c_PW-1:0]      w_s1_prod;
    logic [c_PW-1:0]      r_s2_prod;
    logic [c_PW:0]        w_round;
    logic [c_PW:0]        w_res;
    logic [BITS-1:0]      w_clip;
    logic [BITS-1:0]      r_out_raw;
    logic [2:0]           r_href_sr;
    logic [2:0]           r_vsync_sr;

    assign w_vsync_rise = pix_in.vsync & ~r_vsync_prev;
    assign w_fmt        = fmt_e'(2'(BAYER) ^ {r_odd_line, r_odd_pix});

    // Bayer phase: pixel parity within a line, line parity within a frame
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_odd_pix    <= 1'b0;
            r_odd_line   <= 1'b0;
            r_href_prev  <= 1'b0;
            r_vsync_prev <= 1'b0;
        end else begin
            r_odd_pix    <= pix_in.href ? ~r_odd_pix : 1'b0;
            r_href_prev  <= pix_in.href;
            r_vsync_prev <= pix_in.vsync;
            if (pix_in.vsync) begin
                r_odd_line <= 1'b0;
            end else if (r_href_prev && !pix_in.href) begin
                r_odd_line <= ~r_odd_line;
            end
        end
    end

    // Gains are shadowed so a frame is never processed with mixed settings
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_gain[i] <= GAIN_BITS'(c_GAIN_UNITY);
            end
        end else if (w_vsync_rise) begin
            r_gain[FMT_R]  <= gain_r;
            r_gain[FMT_GR] <= gain_gr;
            r_gain[FMT_GB] <= gain_gb;
            r_gain[FMT_B]  <= gain_b;
        end
    end

    assign w_s1_prod = c_PW'(r_s1_raw) * c_PW'(r_gain[r_s1_fmt]);
    assign w_round   = {1'b0, r_s2_prod} + (c_PW+1)'(c_ROUND);
    assign w_res     = w_round >> c_GAIN_FRAC;
    assign w_clip    = (|w_res[c_PW:BITS]) ? {BITS{1'b1}} : w_res[BITS-1:0];

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_s1_raw   <= '0;
            r_s1_fmt   <= FMT_R;
            r_s2_prod  <= '0;
            r_out_raw  <= '0;
            r_href_sr  <= '0;
            r_vsync_sr <= '0;
        end else begin
            r_s1_raw   <= pix_in.raw;
            r_s1_fmt   <= w_fmt;
            r_s2_prod  <= w_s1_prod;
            // Blank the pixel whenever the line-valid entering stage 3 is low
            r_out_raw  <= r_href_sr[1] ? w_clip : '0;
            r_href_sr  <= {r_href_sr[1:0], pix_in.href};
            r_vsync_sr <= {r_vsync_sr[1:0], pix_in.vsync};
        end
    end

    assign pix_out.href  = r_href_sr[2];
    assign pix_out.vsync = r_vsync_sr[2];
    assign pix_out.raw   = r_out_raw;

    isp_wb_stat #(
        .BITS      (BITS),
        .STAT_BITS (STAT_BITS)
    ) u_stat (
        .pclk        (pclk),
        .rst         (rst),
        .acc_en      (pix_in.href & ~pix_in.vsync),
        .fmt         (w_fmt),
        .raw         (pix_in.raw),
        .vsync_rise  (w_vsync_rise),
        .stat_sum_r  (stat_sum_r),
        .stat_sum_gr (stat_sum_gr),
        .stat_sum_gb (stat_sum_gb),
        .stat_sum_b  (stat_sum_b),
        .stat_done   (stat_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_isp_wb.sv
`default_nettype none
// ============================================================================
// Module  : tb_isp_wb
// Brief   : Scoreboard bench for isp_wb, RGGB and BGGR instances on one stream.
// Revision: 1.0 - initial release
// ============================================================================
module tb_isp_wb;

    logic        pclk = 1'b0;
    logic        rst;
    logic [7:0]  gain_r, gain_gr, gain_gb, gain_b;
    logic [31:0] s0_r, s0_gr, s0_gb, s0_b, s1_r, s1_gr, s1_gb, s1_b;
    logic        s0_done, s1_done;

    always #5 pclk = ~pclk;

    isp_wb_if #(.BITS(8)) pin   ();
    isp_wb_if #(.BITS(8)) pout0 ();
    isp_wb_if #(.BITS(8)) pout1 ();

    isp_wb #(.BITS(8), .GAIN_BITS(8), .STAT_BITS(32), .BAYER(0)) u_dut0 (
        .pclk(pclk), .rst(rst),
        .gain_r(gain_r), .gain_gr(gain_gr), .gain_gb(gain_gb), .gain_b(gain_b),
        .pix_in(pin.slave), .pix_out(pout0.master),
        .stat_sum_r(s0_r), .stat_sum_gr(s0_gr), .stat_sum_gb(s0_gb), .stat_sum_b(s0_b),
        .stat_done(s0_done)
    );

    isp_wb #(.BITS(8), .GAIN_BITS(8), .STAT_BITS(32), .BAYER(3)) u_dut1 (
        .pclk(pclk), .rst(rst),
        .gain_r(gain_r), .gain_gr(gain_gr), .gain_gb(gain_gb), .gain_b(gain_b),
        .pix_in(pin.slave), .pix_out(pout1.master),
        .stat_sum_r(s1_r), .stat_sum_gr(s1_gr), .stat_sum_gb(s1_gb), .stat_sum_b(s1_b),
        .stat_done(s1_done)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  q0 [$];
    logic [7:0]  q1 [$];
    logic [127:0] sq [$];
    logic [31:0] acc [4];
    int          line, col;
    bit          mon_en   = 1'b0;
    bit          mon_skip = 1'b0;
    logic        done_prev = 1'b0;
    logic [2:0]  h_hist, v_hist;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference for the 3-cycle sync delay, cleared by reset like any register
    always @(posedge pclk) begin
        if (rst) begin
            h_hist <= '0;
            v_hist <= '0;
        end else begin
            h_hist <= {h_hist[1:0], pin.href};
            v_hist <= {v_hist[1:0], pin.vsync};
        end
    end

    // Monitor: pops expectations whenever a DUT presents a pixel or stats
    always @(negedge pclk) begin
        if (mon_en) begin
            chk("out_href_delay",  32'(pout0.href),  32'(h_hist[2]));
            chk("out_vsync_delay", 32'(pout0.vsync), 32'(v_hist[2]));
            chk("out_href_delay_b3", 32'(pout1.href), 32'(h_hist[2]));
            if (!pout0.href) chk("out_raw_blank", 32'(pout0.raw), 0);
            if (!pout1.href) chk("out_raw_blank_b3", 32'(pout1.raw), 0);
            if (pout0.href && !mon_skip) begin
                if (q0.size() == 0) chk("unexpected_pix", 1, 0);
                else chk("pix_rggb", 32'(pout0.raw), 32'(q0.pop_front()));
            end
            if (pout1.href && !mon_skip) begin
                if (q1.size() == 0) chk("unexpected_pix_b3", 1, 0);
                else chk("pix_bggr", 32'(pout1.raw), 32'(q1.pop_front()));
            end
            if (s0_done) begin
                chk("stat_done_width", 32'(done_prev), 0);
                if (sq.size() == 0) chk("unexpected_stat_done", 1, 0);
                else begin
                    logic [127:0] e;
                    e = sq.pop_front();
                    chk("stat_sum_r",  s0_r,  e[127:96]);
                    chk("stat_sum_gr", s0_gr, e[95:64]);
                    chk("stat_sum_gb", s0_gb, e[63:32]);
                    chk("stat_sum_b",  s0_b,  e[31:0]);
                end
            end
            done_prev <= s0_done;
        end
    end

    task automatic put_pix(input logic [7:0] r, input logic [7:0] e0, input logic [7:0] e1);
        pin.href = 1'b1; pin.vsync = 1'b0; pin.raw = r;
        if (!mon_skip) begin
            q0.push_back(e0);
            q1.push_back(e1);
        end
        acc[{line[0], col[0]}] += 32'(r);
        col++;
    endtask

    task automatic pix(input logic [7:0] r, input logic [7:0] e0, input logic [7:0] e1);
        @(negedge pclk);
        put_pix(r, e0, e1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            pin.href = 1'b0; pin.vsync = 1'b0; pin.raw = '0;
            if (col != 0) begin
                line++;
                col = 0;
            end
        end
    endtask

    // Frame boundary: stats of the frame just ended are latched at this rise
    task automatic vs();
        @(negedge pclk);
        pin.href = 1'b0; pin.vsync = 1'b1; pin.raw = '0;
        sq.push_back({acc[0], acc[1], acc[2], acc[3]});
        for (int i = 0; i < 4; i++) acc[i] = '0;
        line = 0; col = 0;
        @(negedge pclk);
        idle(1);
    endtask

    // Four pixels, first pixel in the most significant byte
    task automatic line4(input logic [31:0] r, input logic [31:0] e0, input logic [31:0] e1);
        for (int i = 3; i >= 0; i--) pix(r[8*i +: 8], e0[8*i +: 8], e1[8*i +: 8]);
        idle(1);
    endtask

    task automatic set_gains(input logic [7:0] r, input logic [7:0] gr,
                             input logic [7:0] gb, input logic [7:0] b);
        gain_r = r; gain_gr = gr; gain_gb = gb; gain_b = b;
    endtask

    initial begin
        rst = 1'b1;
        set_gains(16, 16, 16, 16);
        pin.href = 1'b0; pin.vsync = 1'b0; pin.raw = '0;
        for (int i = 0; i < 4; i++) acc[i] = '0;
        line = 0; col = 0;
        repeat (2) @(negedge pclk);
        mon_en = 1'b1;
        chk("reset_out_raw",   32'(pout0.raw), 0);
        chk("reset_out_href",  32'(pout0.href), 0);
        chk("reset_stat_done", 32'(s0_done), 0);
        chk("reset_stat_sum",  s0_r | s0_gr | s0_gb | s0_b, 0);
        rst = 1'b0;
        idle(2);
        vs();

        // Unity ramp on a 16x4 frame
        for (int l = 0; l < 4; l++) begin
            for (int c = 0; c < 16; c++) begin
                logic [7:0] v;
                v = 8'((l * 16 + c) * 255 / 63);
                pix(v, v, v);
            end
            idle(1);
        end
        set_gains(32, 16, 16, 16);
        vs();

        // R at 2.0x: 100->200, 200->255 clip
        line4({8'd100, 8'd50, 8'd200, 8'd60}, {8'd200, 8'd50, 8'd255, 8'd60}, {8'd100, 8'd50, 8'd200, 8'd60});
        line4({8'd70, 8'd80, 8'd90, 8'd40},   {8'd70, 8'd80, 8'd90, 8'd40},   {8'd70, 8'd160, 8'd90, 8'd80});
        set_gains(16, 24, 16, 16);
        vs();

        // Gr at 1.5x, then gains change mid-frame and must not apply yet
        line4({8'd9, 8'd5, 8'd9, 8'd7}, {8'd9, 8'd8, 8'd9, 8'd11}, {8'd9, 8'd5, 8'd9, 8'd7});
        line4({8'd5, 8'd5, 8'd7, 8'd7}, {8'd5, 8'd5, 8'd7, 8'd7},  {8'd8, 8'd5, 8'd11, 8'd7});
        set_gains(32, 0, 16, 16);
        line4({8'd100, 8'd3, 8'd150, 8'd3}, {8'd100, 8'd5, 8'd150, 8'd5}, {8'd100, 8'd3, 8'd150, 8'd3});
        vs();

        // New gains from the first pixel after vsync; Gr gain 0 gives 0
        line4({8'd100, 8'd5, 8'd50, 8'd255}, {8'd200, 8'd0, 8'd100, 8'd0}, {8'd100, 8'd5, 8'd50, 8'd255});
        line4({8'd20, 8'd30, 8'd40, 8'd50},  {8'd20, 8'd30, 8'd40, 8'd50}, {8'd0, 8'd60, 8'd0, 8'd100});
        set_gains(16, 16, 16, 16);
        vs();

        // 4x4 statistics frame: expected sums R=40 Gr=80 Gb=80 B=120
        for (int l = 0; l < 2; l++) begin
            line4({8'd10, 8'd20, 8'd10, 8'd20}, {8'd10, 8'd20, 8'd10, 8'd20}, {8'd10, 8'd20, 8'd10, 8'd20});
            line4({8'd20, 8'd30, 8'd20, 8'd30}, {8'd20, 8'd30, 8'd20, 8'd30}, {8'd20, 8'd30, 8'd20, 8'd30});
        end
        vs();
        pix(1, 1, 1);
        idle(1);
        vs();
        idle(4);

        // Reset mid-line with a pending non-unity gain on the inputs
        set_gains(32, 16, 16, 16);
        mon_skip = 1'b1;
        pix(10, 10, 10);
        pix(20, 20, 20);
        pix(30, 30, 30);
        @(negedge pclk);
        rst = 1'b1; pin.raw = 8'd50;
        @(negedge pclk);
        chk("rst_mid_out_raw",   32'(pout0.raw), 0);
        chk("rst_mid_out_href",  32'(pout0.href), 0);
        chk("rst_mid_stat_done", 32'(s0_done), 0);
        mon_skip = 1'b0;
        pin.raw = 8'd60;
        @(negedge pclk);
        chk("rst_mid_out_href2", 32'(pout0.href), 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) acc[i] = '0;
        line = 0; col = 0;
        put_pix(200, 200, 200);
        pix(40, 40, 40);
        pix(200, 200, 200);
        idle(4);
        vs();
        pix(100, 200, 100);
        idle(8);
        vs();
        idle(6);

        chk("pending_pix_rggb", q0.size(), 0);
        chk("pending_pix_bggr", q1.size(), 0);
        chk("pending_stats",    sq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
